// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: RiSC-16 instruction memory with a runtime loader and a post-reset clear sweep.
// Ports:
//   clk0, reset (sync, active-low)
//   csb0/addr0 -> dout0/dvalid0 : fetch port, one-cycle registered latency
//   busy                        : high while clearing or loading (core stalls)
//   ld_start/ld_len             : begin a load of ld_len words
//   ld_valid/ld_data/ld_ready   : loader word handshake
//   ld_done/ld_err              : one-cycle completion / illegal-length pulses
module instruction_memory_loadable #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              csb0,
  input  logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] dout0,
  output logic              dvalid0,
  output logic              busy,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
  state_t            r_state;
  logic [ADDR_W:0]   r_ptr, r_len;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid, r_done, r_err;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W:0]   w_ptr_inc;
  logic              w_bad_len;
  assign w_ptr_inc = r_ptr + {{ADDR_W{1'b0}}, 1'b1};
  assign w_bad_len = (ld_len == '0) || (ld_len > {1'b1, {ADDR_W{1'b0}}});
  // Writes are gated by reset so the array is never touched while reset is held.
  assign w_we    = reset && ((r_state == CLEAR) || (r_state == LOAD && ld_valid));
  assign w_wdata = (r_state == LOAD) ? ld_data : '0;
  assign busy     = r_state != IDLE;
  assign ld_ready = r_state == LOAD;
  assign dout0    = r_dout;
  assign dvalid0  = r_dvalid;
  assign ld_done  = r_done;
  assign ld_err   = r_err;
  always_ff @(posedge clk0) begin
    if (w_we) r_mem[r_ptr[ADDR_W-1:0]] <= w_wdata;
  end
  always_ff @(posedge clk0) begin
    if (!reset) begin
      r_state  <= CLEAR;
      r_ptr    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_dout   <= '0;
          r_dvalid <= 1'b0;
          r_ptr    <= w_ptr_inc;
          if (r_ptr[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end
        end
        IDLE: begin
          // A fetch issued alongside ld_start is still serviced.
          if (!csb0) r_dout <= r_mem[addr0];
          r_dvalid <= !csb0;
          if (ld_start) begin
            if (w_bad_len) r_err <= 1'b1;
            else begin
              r_len   <= ld_len;
              r_ptr   <= '0;
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          r_dout   <= '0;
          r_dvalid <= 1'b0;
          if (ld_valid) begin
            r_ptr <= w_ptr_inc;
            if (w_ptr_inc == r_len) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: directed self-checking bench for instruction_memory_loadable.
module tb_instruction_memory_loadable;
  logic        clk0 = 1'b0;
  logic        reset, csb0, ld_start, ld_valid;
  logic [5:0]  addr0;
  logic [6:0]  ld_len;
  logic [15:0] ld_data;
  logic [15:0] dout0;
  logic        dvalid0, busy, ld_ready, ld_done, ld_err;
  int          n_checks = 0;
  int          n_fail = 0;
  instruction_memory_loadable dut (
    .clk0(clk0), .reset(reset), .csb0(csb0), .addr0(addr0), .dout0(dout0),
    .dvalid0(dvalid0), .busy(busy), .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err)
  );
  always #5 clk0 = ~clk0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk0);
    #1;
  endtask
  task automatic fetch(input logic [5:0] a, input logic [15:0] exp);
    addr0 = a;
    csb0  = 1'b0;
    tick();
    check($sformatf("fetch[%0d]", a), dout0, exp);
    check("fetch_dvalid", dvalid0, 1);
    csb0 = 1'b1;
  endtask
  task automatic start_load(input logic [6:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
    check("load_busy", busy, 1);
    check("load_ready", ld_ready, 1);
  endtask
  task automatic put(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    check("put_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    check("put_done", ld_done, last);
    check("put_busy", busy, !last);
  endtask
  task automatic sweep(input string tag);
    int n = 0;
    bit done_seen = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (ld_done) done_seen = 1;
    end
    check({tag, "_cycles"}, n, 64);
    check({tag, "_no_done"}, done_seen, 0);
  endtask
  initial begin
    reset = 1'b0; csb0 = 1'b1; addr0 = '0; ld_start = 1'b0;
    ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    repeat (3) tick();
    check("rst_dout", dout0, 0);
    check("rst_dvalid", dvalid0, 0);
    check("rst_done", ld_done, 0);
    check("rst_err", ld_err, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", ld_ready, 0);
    reset = 1'b1;
    sweep("clear");
    check("idle_busy", busy, 0);
    for (int a = 0; a < 64; a++) fetch(6'(a), 16'h0000);
    // Three-word load with ld_valid held high.
    start_load(7'd3);
    put(16'h8418, 0);
    put(16'h8819, 0);
    put(16'h3400, 1);
    tick();
    check("done_one_cycle", ld_done, 0);
    fetch(6'd0, 16'h8418);
    fetch(6'd1, 16'h8819);
    fetch(6'd2, 16'h3400);
    fetch(6'd3, 16'h0000);
    // Two-word load with stalls; a fetch issued with ld_start is still served.
    addr0 = 6'd2;
    csb0  = 1'b0;
    start_load(7'd2);
    check("start_fetch", dout0, 16'h3400);
    check("start_fetch_dvalid", dvalid0, 1);
    csb0 = 1'b1;
    put(16'hc092, 0);
    check("load_dout_zero", dout0, 0);
    check("load_dvalid_zero", dvalid0, 0);
    repeat (2) begin
      tick();
      check("stall_ready", ld_ready, 1);
      check("stall_done", ld_done, 0);
    end
    put(16'hc111, 1);
    fetch(6'd0, 16'hc092);
    fetch(6'd1, 16'hc111);
    fetch(6'd2, 16'h3400);
    fetch(6'd3, 16'h0000);
    // Illegal lengths.
    ld_start = 1'b1; ld_len = 7'd0;
    tick();
    check("err_len0", ld_err, 1);
    check("err_len0_busy", busy, 0);
    ld_len = 7'd65;
    tick();
    check("err_len65", ld_err, 1);
    check("err_len65_busy", busy, 0);
    ld_start = 1'b0;
    tick();
    check("err_cleared", ld_err, 0);
    fetch(6'd0, 16'hc092);
    fetch(6'd1, 16'hc111);
    // Full 64-word load; a second ld_start mid-load must be ignored.
    start_load(7'd64);
    for (int a = 0; a < 64; a++) begin
      if (a == 10) begin
        ld_start = 1'b1;
        ld_len   = 7'd2;
      end
      put(16'(a) ^ 16'hA5A5, a == 63);
      if (a == 10) begin
        ld_start = 1'b0;
        check("ignored_start_err", ld_err, 0);
      end
    end
    for (int a = 0; a < 64; a++) fetch(6'(a), 16'(a) ^ 16'hA5A5);
    // Reset partway through a five-word load.
    start_load(7'd5);
    put(16'h1111, 0);
    put(16'h2222, 0);
    reset = 1'b0;
    tick();
    check("abort_done", ld_done, 0);
    check("abort_busy", busy, 1);
    reset = 1'b1;
    sweep("reclear");
    fetch(6'd0, 16'h0000);
    fetch(6'd1, 16'h0000);
    fetch(6'd2, 16'h0000);
    // Single-word load, then dout0 holds across a deselected cycle.
    start_load(7'd1);
    put(16'hd182, 1);
    fetch(6'd0, 16'hd182);
    addr0 = 6'd5;
    tick();
    check("hold_dout", dout0, 16'hd182);
    check("hold_dvalid", dvalid0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
Parametrised instruction memory for the RiSC-16 core. It replaces fixed in-RTL program contents with a runtime loader port that streams program words in over a valid/ready handshake. After reset, the block zeroes the whole array through a hardware sweep. It serves the core's fetch port with one-cycle registered latency and sits between the core fetch stage and an external program loader (UART/debug bridge).

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 6, address width; depth DEPTH = 2**ADDR_W words (derived, not overridable)

Ports:
clk0  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
csb0  input  1  fetch chip select, active-low
addr0  input  ADDR_W  fetch word address
dout0  output  DATA_W  registered fetch data
dvalid0  output  1  registered; high when dout0 holds a fresh fetch result
busy  output  1  high in CLEAR or LOAD states (core must stall)
ld_start  input  1  single-cycle request to begin a load
ld_len  input  ADDR_W+1  number of words to load, sampled with ld_start
ld_valid  input  1  loader word valid
ld_data  input  DATA_W  loader word
ld_ready  output  1  block accepts ld_data this cycle
ld_done  output  1  one-cycle pulse after the final word is written
ld_err  output  1  one-cycle pulse on an illegal ld_len

Behaviour:
- Reset (reset==0 at posedge): state<=CLEAR, ptr<=0, dout0<=0, dvalid0<=0, ld_done<=0, ld_err<=0. Array contents are not touched during reset.
- busy and ld_ready are decoded combinationally from state. busy=1 in CLEAR/LOAD. ld_ready=1 only in LOAD.
- States: CLEAR, IDLE, LOAD.
- CLEAR: each cycle writes mem[ptr]<=0 and increments ptr. The write at ptr==DEPTH-1 moves to IDLE with ptr<=0. The sweep takes exactly DEPTH cycles after reset release.
- IDLE, csb0==0: dout0<=mem[addr0], dvalid0<=1. Data appears the cycle after the address (latency 1).
- IDLE, csb0==1: dout0 holds its previous value, dvalid0<=0.
- CLEAR/LOAD, any csb0: dout0<=0, dvalid0<=0.
- IDLE, ld_start==1, 1<=ld_len<=DEPTH: latch len<=ld_len, ptr<=0, go to LOAD. A fetch in the same cycle is still serviced.
- IDLE, ld_start==1, ld_len==0 or ld_len>DEPTH: ld_err<=1 for one cycle, stay in IDLE.
- ld_start outside IDLE is ignored, with no error.
- LOAD: on ld_valid&&ld_ready, write mem[ptr]<=ld_data and ptr<=ptr+1. ld_valid low stalls with no timeout.
- LOAD, final word (ptr==len-1 accepted): go to IDLE and set ld_done<=1 for one cycle (the cycle IDLE is entered).
- Words at addresses >= len keep their previous contents: zero after a sweep, or earlier loaded data.
- ptr is ADDR_W+1 bits wide, so a full DEPTH load reaches ptr==DEPTH without aliasing. Writes use ptr[ADDR_W-1:0].
- Reset mid-CLEAR or mid-LOAD aborts the operation and restarts the full CLEAR sweep after release. Partially loaded words are then zeroed. No ld_done is issued.
- Read/write collision is impossible: fetches return 0 while any write state is active.
- ld_done and ld_err default to 0 in every cycle where they are not pulsed.

Test Plan:
- Reset low 3 cycles, then high → busy=1 for exactly 64 cycles, then 0. Fetch of addr0=0..63 with csb0=0 returns 16'h0000 with dvalid0=1, one cycle after each address.
- In IDLE, ld_start with ld_len=3, then stream 16'h8418, 16'h8819, 16'h3400 with ld_valid held high → ld_ready high 3 cycles, ld_done pulses once, busy drops. Fetches of addr 0,1,2,3 return 8418, 8819, 3400, 0000.
- Load ld_len=2 with ld_valid toggling 1,0,0,1 → only 2 writes occur (c092 at addr 0, c111 at addr 1). The stall cycles add no writes. ld_done follows the second accept.
- ld_start with ld_len=0, then ld_len=65 → ld_err pulses each time, busy stays 0, memory unchanged. ld_len=64 full load of pattern addr^16'hA5A5 → every address reads back correctly.
- Mid-load reset after 2 of 5 words (ld_len=5) → no ld_done, 64-cycle CLEAR sweep, then addr 0 and 1 read 0000.
- csb0=1 after a fetch returning d182 → dout0 stays d182, dvalid0=0. ld_start asserted during LOAD → ignored, original len completes.
